// File: rtl/triple_rep_tx.sv
// rtl/triple_rep_tx.sv - triple-repetition serial frame transmitter
//
// Sends each accepted DATA_W-bit word as a serial frame: start (0), data bits
// LSB first, optional even parity, stop (1). Every symbol is held for exactly
// three clock cycles so a 3-sample majority-vote receiver can absorb one
// corrupted sample per symbol.
//
// Optional feature macro: TRIPLE_REP_PARITY_EN (adds a PARITY symbol between
// the last data bit and the stop symbol).
//
// Ports:
//   CLK        in   clock, all state changes on rising edge
//   RST        in   asynchronous active-high reset
//   DIN        in   payload word, sent LSB first
//   DIN_VALID  in   producer offers DIN this cycle
//   DIN_READY  out  word accepted on the edge where DIN_VALID & DIN_READY
//   TX_OUT     out  registered serial line, idle high
//   TX_ACTIVE  out  high from first start cycle through last stop cycle
//   FRAME_DONE out  one-cycle pulse in the final stop cycle

module triple_rep_tx #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              TX_OUT,
    output logic              TX_ACTIVE,
    output logic              FRAME_DONE
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef TRIPLE_REP_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [1:0]          rep_q, rep_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_out_q, tx_out_d;
    logic                ready_q, ready_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
`ifdef TRIPLE_REP_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic accept;
    logic rep_last;

    always_comb begin
        state_d  = state_q;
        rep_d    = rep_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef TRIPLE_REP_PARITY_EN
        parity_d = parity_q;
`endif
        // ready_q is the registered DIN_READY, so acceptance matches what the
        // producer sees on the port.
        accept   = DIN_VALID & ready_q;
        rep_last = (rep_q == 2'd2);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_START;
                    rep_d    = 2'd0;
                    shift_d  = DIN;
`ifdef TRIPLE_REP_PARITY_EN
                    parity_d = ^DIN;
`endif
                end
            end
            S_START: begin
                if (rep_last) begin
                    state_d = S_DATA;
                    rep_d   = 2'd0;
                    idx_d   = '0;
                end else begin
                    rep_d = rep_q + 2'd1;
                end
            end
            S_DATA: begin
                if (rep_last) begin
                    rep_d = 2'd0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef TRIPLE_REP_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    rep_d = rep_q + 2'd1;
                end
            end
`ifdef TRIPLE_REP_PARITY_EN
            S_PARITY: begin
                if (rep_last) begin
                    state_d = S_STOP;
                    rep_d   = 2'd0;
                end else begin
                    rep_d = rep_q + 2'd1;
                end
            end
`endif
            S_STOP: begin
                if (rep_last) begin
                    rep_d = 2'd0;
                    // Back-to-back: a word accepted in the final stop cycle
                    // starts the next frame with no idle gap.
                    if (accept) begin
                        state_d  = S_START;
                        shift_d  = DIN;
`ifdef TRIPLE_REP_PARITY_EN
                        parity_d = ^DIN;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    rep_d = rep_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rep_d   = 2'd0;
                idx_d   = '0;
            end
        endcase

        // All outputs are registered from the next-state values so the line
        // changes on the same edge as the state it represents.
        tx_out_d = 1'b1;
        case (state_d)
            S_START:  tx_out_d = 1'b0;
            S_DATA:   tx_out_d = shift_d[0];
`ifdef TRIPLE_REP_PARITY_EN
            S_PARITY: tx_out_d = parity_d;
`endif
            default:  tx_out_d = 1'b1;
        endcase
        done_d   = (state_d == S_STOP) && (rep_d == 2'd2);
        ready_d  = (state_d == S_IDLE) || done_d;
        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            rep_q    <= 2'd0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef TRIPLE_REP_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rep_q    <= rep_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifdef TRIPLE_REP_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign DIN_READY  = ready_q;
    assign TX_OUT     = tx_out_q;
    assign TX_ACTIVE  = active_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_triple_rep_tx.sv
// tb/tb_triple_rep_tx.sv - self-checking bench for triple_rep_tx
module tb_triple_rep_tx;

    localparam int DW = 8;
`ifdef TRIPLE_REP_PARITY_EN
    localparam int FRAME_LEN = 3 * (DW + 3);
`else
    localparam int FRAME_LEN = 3 * (DW + 2);
`endif

    logic          CLK;
    logic          RST;
    logic [DW-1:0] DIN;
    logic          DIN_VALID;
    logic          DIN_READY;
    logic          TX_OUT;
    logic          TX_ACTIVE;
    logic          FRAME_DONE;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];   // {frame_done, line} per expected cycle
    logic       cap[$];     // captured line samples while TX_ACTIVE
    int         active_cnt;
    int         done_cnt;
    int         run_len;
    int         max_run;

    triple_rep_tx #(.DATA_W(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .TX_OUT     (TX_OUT),
        .TX_ACTIVE  (TX_ACTIVE),
        .FRAME_DONE (FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected line for one word: each symbol repeated three times.
    task automatic push_frame(input logic [DW-1:0] w);
        for (int r = 0; r < 3; r++) exp_q.push_back(2'b00);
        for (int b = 0; b < DW; b++)
            for (int r = 0; r < 3; r++) exp_q.push_back({1'b0, w[b]});
`ifdef TRIPLE_REP_PARITY_EN
        for (int r = 0; r < 3; r++) exp_q.push_back({1'b0, ^w});
`endif
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
    endtask

    task automatic clr_stats();
        active_cnt = 0;
        done_cnt   = 0;
        run_len    = 0;
        max_run    = 0;
        cap.delete();
    endtask

    task automatic tick();
        logic          acc;
        logic [DW-1:0] w;
        logic [1:0]    e;
        logic          has;
        acc = DIN_VALID && DIN_READY;
        w   = DIN;
        @(posedge CLK);
        #1;
        if (acc) push_frame(w);
        has = (exp_q.size() > 0);
        e   = has ? exp_q.pop_front() : 2'b01;
        check(32'(TX_OUT), 32'(e[0]), "tx_out");
        check(32'(TX_ACTIVE), 32'(has), "tx_active");
        check(32'(FRAME_DONE), 32'(e[1]), "frame_done");
        check(32'(DIN_READY), 32'(exp_q.size() == 0), "din_ready");
        if (TX_ACTIVE) begin
            active_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            cap.push_back(TX_OUT);
        end else begin
            run_len = 0;
        end
        if (FRAME_DONE) done_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Majority-vote receiver with one flipped sample per symbol.
    function automatic logic [DW-1:0] vote_decode(input int first);
        logic [DW-1:0] w;
        w = '0;
        for (int b = 0; b < DW; b++) begin
            int   base;
            int   f;
            logic s0, s1, s2;
            base = first + 3 * (1 + b);
            f  = int'($urandom_range(0, 2));
            s0 = cap[base]     ^ (f == 0);
            s1 = cap[base + 1] ^ (f == 1);
            s2 = cap[base + 2] ^ (f == 2);
            w[b] = (s0 & s1) | (s0 & s2) | (s1 & s2);
        end
        return w;
    endfunction

    task automatic single_frame(input logic [DW-1:0] w, input string tag);
        clr_stats();
        DIN = w;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        DIN = ~w;
        ticks(FRAME_LEN + 4);
        check(32'(active_cnt), 32'(FRAME_LEN), {tag, "_len"});
        check(32'(done_cnt), 32'd1, {tag, "_done"});
        check(32'(cap.size() >= FRAME_LEN ? vote_decode(0) : ~w), 32'(w), {tag, "_vote"});
    endtask

    initial begin
        logic [0:FRAME_LEN-1] golden;
        logic [0:FRAME_LEN-1] got;
        int guard;

        RST = 1'b1;
        DIN = '0;
        DIN_VALID = 1'b0;
        clr_stats();

        // Reset state
        #1;
        check(32'(TX_OUT), 32'd1, "rst_tx_out");
        check(32'(DIN_READY), 32'd0, "rst_ready");
        check(32'(TX_ACTIVE), 32'd0, "rst_active");
        check(32'(FRAME_DONE), 32'd0, "rst_done");
        #21;
        RST = 1'b0;
        tick();
        check(32'(DIN_READY), 32'd1, "ready_after_release");
        ticks(2);

        // 8'hA5 against a hand-written line pattern
`ifdef TRIPLE_REP_PARITY_EN
        golden = 33'b000_111_000_111_000_000_111_000_111_000_111;
`else
        golden = 30'b000_111_000_111_000_000_111_000_111_111;
`endif
        single_frame(8'hA5, "a5");
        got = '0;
        for (int i = 0; i < FRAME_LEN && i < cap.size(); i++) got[i] = cap[i];
        check(32'(got == golden), 32'd1, "a5_pattern");

        // Back-to-back 8'h00 then 8'hFF
        clr_stats();
        DIN = 8'h00;
        DIN_VALID = 1'b1;
        tick();
        DIN = 8'hFF;
        guard = 0;
        while (!DIN_READY && guard < 2 * FRAME_LEN) begin
            tick();
            guard++;
        end
        check(32'(guard < 2 * FRAME_LEN), 32'd1, "b2b_ready_timeout");
        tick();
        DIN_VALID = 1'b0;
        ticks(FRAME_LEN + 4);
        check(32'(max_run), 32'(2 * FRAME_LEN), "b2b_active_run");
        check(32'(done_cnt), 32'd2, "b2b_done_count");

        // DIN changes right after acceptance must not affect the line
        clr_stats();
        DIN = 8'hC3;
        DIN_VALID = 1'b1;
        tick();
        DIN = 8'h3C;
        DIN_VALID = 1'b0;
        ticks(FRAME_LEN + 3);
        check(32'(cap.size() >= FRAME_LEN ? vote_decode(0) : 8'h00), 32'hC3, "c3_hold");

        // Parity-relevant words
        single_frame(8'h07, "w07");
        single_frame(8'h03, "w03");

        // Randomized words, gaps and occasional back-to-back offers
        for (int k = 0; k < 8; k++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                single_frame(w, "rnd");
            end else begin
                DIN = w;
                DIN_VALID = 1'b1;
                tick();
                DIN = DW'($urandom);
                guard = 0;
                while (!DIN_READY && guard < 2 * FRAME_LEN) begin
                    tick();
                    guard++;
                end
                check(32'(guard < 2 * FRAME_LEN), 32'd1, "rnd_ready_timeout");
                tick();
                DIN_VALID = 1'b0;
                ticks(FRAME_LEN + 2);
            end
            ticks(int'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-frame
        clr_stats();
        DIN = 8'h5A;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        ticks(10);
        #3;
        RST = 1'b1;
        #1;
        exp_q.delete();
        check(32'(TX_OUT), 32'd1, "midrst_tx_out");
        check(32'(DIN_READY), 32'd0, "midrst_ready");
        check(32'(TX_ACTIVE), 32'd0, "midrst_active");
        check(32'(FRAME_DONE), 32'd0, "midrst_done");
        @(posedge CLK);
        #2;
        check(32'(TX_OUT), 32'd1, "midrst_hold_tx_out");
        RST = 1'b0;
        clr_stats();
        tick();
        check(32'(DIN_READY), 32'd1, "midrst_ready_release");
        ticks(FRAME_LEN);
        check(32'(done_cnt), 32'd0, "midrst_no_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
